// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM port arbiter: default address width,
// controller state encoding and requester index constants.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from vld; the
// register remembers which requester won last so ties alternate.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] vld,
  output logic [1:0] gnt
);

  logic last_grant;

  // One-hot grant: a lone requester wins, a tie goes to the one that did not win last.
  always_comb begin
    // NOTE: default every output first so no path leaves gnt unassigned (no latch).
    gnt = 2'b00;
    if (rst_n && en) begin
      case (vld)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == 1'(REQ1)) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Remember the winner; idle cycles leave the history untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (gnt != 2'b00) begin
      last_grant <= gnt[REQ1];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Front end for a single-port 1-bit RAM: round-robin sharing between two
// valid/ready requesters, one-cycle read responses and a clear sweep.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int   ADDR_W  = ADDR_W_DEF,
  parameter int   DEPTH   = 2**ADDR_W,
  parameter logic CLR_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_vld,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_wdata,
  output logic              req0_rdy,
  output logic              req0_rsp_vld,
  output logic              req0_rsp_data,
  input  logic              req1_vld,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_wdata,
  output logic              req1_rdy,
  output logic              req1_rsp_vld,
  output logic              req1_rsp_data,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              ram_we,
  input  logic              ram_q
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] addr_hold;
  logic [1:0]        gnt;
  logic [1:0]        rsp_vld_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == SERVE),
    .vld   ({req1_vld, req0_vld}),
    .gnt   (gnt)
  );

  assign req0_rdy = gnt[REQ0];
  assign req1_rdy = gnt[REQ1];

  // The RAM registers its read address, so q already belongs to the response cycle.
  assign req0_rsp_data = ram_q;
  assign req1_rsp_data = ram_q;
  assign req0_rsp_vld  = rsp_vld_q[REQ0];
  assign req1_rsp_vld  = rsp_vld_q[REQ1];

  assign clr_busy = (state == CLEAR);

  // RAM port mux: sweep address in CLEAR, else the granted requester, else hold the address.
  always_comb begin
    ram_addr = addr_hold;
    ram_data = CLR_VAL;
    ram_we   = 1'b0;
    if (state == CLEAR) begin
      ram_addr = clr_cnt;
      ram_data = CLR_VAL;
      ram_we   = 1'b1;
    end else if (gnt[REQ0]) begin
      ram_addr = req0_addr;
      ram_data = req0_wdata;
      ram_we   = req0_we;
    end else if (gnt[REQ1]) begin
      ram_addr = req1_addr;
      ram_data = req1_wdata;
      ram_we   = req1_we;
    end
  end

  // Serve/clear sequencer with the registered completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SERVE;
      clr_cnt  <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        SERVE: begin
          if (clr_start) begin
            state <= CLEAR;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state    <= SERVE;
            clr_cnt  <= '0;
            clr_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

  // One-cycle read strobes for accepted reads; remember the last driven address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q <= '0;
      addr_hold <= '0;
    end else begin
      rsp_vld_q[REQ0] <= gnt[REQ0] & ~req0_we;
      rsp_vld_q[REQ1] <= gnt[REQ1] & ~req1_we;
      addr_hold       <= ram_addr;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a simple RAM, a transaction-level model of
// the arbiter/clear behaviour, directed scenarios and a random phase.
module tb_ram_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_vld = 1'b0, req0_we = 1'b0, req0_wdata = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic              req1_vld = 1'b0, req1_we = 1'b0, req1_wdata = 1'b0;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic              req0_rdy, req0_rsp_vld, req0_rsp_data;
  logic              req1_rdy, req1_rsp_vld, req1_rsp_data;
  logic              clr_start = 1'b0;
  logic              clr_busy, clr_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data, ram_we, ram_q;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_vld      (req0_vld),
    .req0_we       (req0_we),
    .req0_addr     (req0_addr),
    .req0_wdata    (req0_wdata),
    .req0_rdy      (req0_rdy),
    .req0_rsp_vld  (req0_rsp_vld),
    .req0_rsp_data (req0_rsp_data),
    .req1_vld      (req1_vld),
    .req1_we       (req1_we),
    .req1_addr     (req1_addr),
    .req1_wdata    (req1_wdata),
    .req1_rdy      (req1_rdy),
    .req1_rsp_vld  (req1_rsp_vld),
    .req1_rsp_data (req1_rsp_data),
    .clr_start     (clr_start),
    .clr_busy      (clr_busy),
    .clr_done      (clr_done),
    .ram_addr      (ram_addr),
    .ram_data      (ram_data),
    .ram_we        (ram_we),
    .ram_q         (ram_q)
  );

  // Single-port RAM with registered read address, contents not reset.
  bit                ram_mem [DEPTH];
  logic [ADDR_W-1:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_addr_q <= ram_addr;
  end
  assign ram_q = ram_mem[ram_addr_q];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_seq(string name, int act[$], int exp[$]);
    check({name, "_len"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      check($sformatf("%s_%0d", name, i), act[i], exp[i]);
  endtask

  // Model: memory contents, clear cycles still to run, last winner, pending responses.
  bit m_mem [DEPTH];
  int m_clear_left = 0;
  int m_last       = 1;
  bit m_rsp_vld [2];
  bit m_rsp_val [2];
  bit m_done       = 1'b0;

  // Observation logs consumed by the directed scenarios.
  int hs_log[$];
  int rsp_req_log[$];
  int rsp_dat_log[$];
  int busy_cycles = 0;
  int done_pulses = 0;

  int g, a, ea;
  bit ew, ed;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rdy0", req0_rdy, 0);
      check("rst_rdy1", req1_rdy, 0);
      check("rst_we", ram_we, 0);
      check("rst_rsp0", req0_rsp_vld, 0);
      check("rst_rsp1", req1_rsp_vld, 0);
      check("rst_busy", clr_busy, 0);
      check("rst_done", clr_done, 0);
      m_clear_left = 0;
      m_last       = 1;
      m_rsp_vld    = '{0, 0};
      m_done       = 1'b0;
    end else begin
      g = -1;
      if (m_clear_left == 0) begin
        if (req0_vld && req1_vld) g = (m_last == 1) ? 0 : 1;
        else if (req0_vld)        g = 0;
        else if (req1_vld)        g = 1;
      end
      check("rdy0", req0_rdy, 32'(g == 0));
      check("rdy1", req1_rdy, 32'(g == 1));
      check("busy", clr_busy, 32'(m_clear_left != 0));
      check("done", clr_done, 32'(m_done));
      check("rsp_vld0", req0_rsp_vld, 32'(m_rsp_vld[0]));
      check("rsp_vld1", req1_rsp_vld, 32'(m_rsp_vld[1]));
      if (m_rsp_vld[0]) check("rsp_data0", req0_rsp_data, 32'(m_rsp_val[0]));
      if (m_rsp_vld[1]) check("rsp_data1", req1_rsp_data, 32'(m_rsp_val[1]));

      ea = (g == 1) ? int'(req1_addr) : int'(req0_addr);
      ew = (g == 1) ? req1_we : req0_we;
      ed = (g == 1) ? req1_wdata : req0_wdata;
      if (m_clear_left != 0) begin
        a = DEPTH - m_clear_left;
        check("clr_we", ram_we, 1);
        check("clr_addr", ram_addr, 32'(a));
        check("clr_data", ram_data, 0);
      end else if (g >= 0) begin
        check("acc_we", ram_we, 32'(ew));
        check("acc_addr", ram_addr, 32'(ea));
        if (ew) check("acc_data", ram_data, 32'(ed));
      end else begin
        check("idle_we", ram_we, 0);
      end

      if (req0_vld && req0_rdy) hs_log.push_back(0);
      if (req1_vld && req1_rdy) hs_log.push_back(1);
      if (req0_rsp_vld) begin rsp_req_log.push_back(0); rsp_dat_log.push_back(int'(req0_rsp_data)); end
      if (req1_rsp_vld) begin rsp_req_log.push_back(1); rsp_dat_log.push_back(int'(req1_rsp_data)); end
      busy_cycles += int'(clr_busy);
      done_pulses += int'(clr_done);

      // Advance the model to what the coming edge must do.
      m_rsp_vld = '{0, 0};
      m_done    = 1'b0;
      if (m_clear_left != 0) begin
        m_mem[DEPTH - m_clear_left] = 1'b0;
        m_clear_left--;
        if (m_clear_left == 0) m_done = 1'b1;
      end else begin
        if (g >= 0) begin
          m_last = g;
          if (ew) m_mem[ea] = ed;
          else begin
            m_rsp_vld[g] = 1'b1;
            m_rsp_val[g] = m_mem[ea];
          end
        end
        if (clr_start) m_clear_left = DEPTH;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_vld  = 1'b0;
    req1_vld  = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set0(bit v, bit we, int addr, bit d);
    req0_vld = v; req0_we = we; req0_addr = ADDR_W'(addr); req0_wdata = d;
  endtask

  task automatic set1(bit v, bit we, int addr, bit d);
    req1_vld = v; req1_we = we; req1_addr = ADDR_W'(addr); req1_wdata = d;
  endtask

  // Single access from requester r, alone on the bus, then release.
  task automatic access(int r, bit we, int addr, bit d);
    if (r == 0) set0(1'b1, we, addr, d);
    else        set1(1'b1, we, addr, d);
    tick();
    idle();
  endtask

  task automatic flush();
    hs_log.delete();
    rsp_req_log.delete();
    rsp_dat_log.delete();
  endtask

  int busy0, done0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = 1'($urandom);
      m_mem[i]   = ram_mem[i];
    end
    do_reset();

    // Write then read address 5 from requester 0.
    flush();
    set0(1'b1, 1'b1, 5, 1'b1);
    tick();
    set0(1'b1, 1'b0, 5, 1'b0);
    tick();
    idle();
    @(negedge clk);
    check("t1_rsp_pulse", req0_rsp_vld, 1);
    check("t1_rsp_data", req0_rsp_data, 1);
    tick();
    @(negedge clk);
    check("t1_rsp_end", req0_rsp_vld, 0);
    tick();
    check_seq("t1_hs", hs_log, '{0, 0});
    check_seq("t1_rsp", rsp_req_log, '{0});

    // Both requesters contend for four cycles right after reset.
    do_reset();
    flush();
    set0(1'b1, 1'b0, 3, 1'b0);
    set1(1'b1, 1'b0, 7, 1'b0);
    repeat (4) tick();
    idle();
    tick();
    tick();
    check_seq("t2_hs", hs_log, '{0, 1, 0, 1});
    check_seq("t2_rsp", rsp_req_log, '{0, 1, 0, 1});

    // Requester 1 alone three times, then a tie that requester 0 must win.
    do_reset();
    flush();
    set1(1'b1, 1'b0, 2, 1'b0);
    repeat (3) tick();
    set0(1'b1, 1'b0, 4, 1'b0);
    tick();
    idle();
    tick();
    check_seq("t3_hs", hs_log, '{1, 1, 1, 0});

    // Full clear sweep with contention and an ignored second clr_start.
    access(0, 1'b1, 0, 1'b1);
    access(1, 1'b1, 512, 1'b1);
    access(0, 1'b1, 1023, 1'b1);
    busy0 = busy_cycles;
    done0 = done_pulses;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    set0(1'b1, 1'b0, 11, 1'b0);
    set1(1'b1, 1'b0, 12, 1'b0);
    repeat (100) tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (400) tick();
    idle();
    repeat (530) tick();
    check("t4_busy_cycles", busy_cycles - busy0, 1024);
    check("t4_done_pulses", done_pulses - done0, 1);
    flush();
    access(0, 1'b0, 0, 1'b0);
    access(1, 1'b0, 512, 1'b0);
    access(0, 1'b0, 1023, 1'b0);
    tick();
    check_seq("t4_rd", rsp_dat_log, '{0, 0, 0});

    // Reset in the middle of a sweep at clr_cnt = 300.
    access(0, 1'b1, 299, 1'b1);
    access(0, 1'b1, 301, 1'b1);
    done0 = done_pulses;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (300) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("t5_busy", clr_busy, 0);
    tick();
    check("t5_no_done", done_pulses - done0, 0);
    flush();
    access(1, 1'b0, 299, 1'b0);
    access(0, 1'b0, 301, 1'b0);
    tick();
    check_seq("t5_rd", rsp_dat_log, '{0, 1});

    // Write then read address 9 on consecutive cycles from different requesters.
    flush();
    set0(1'b1, 1'b1, 9, 1'b1);
    tick();
    req0_vld = 1'b0;
    set1(1'b1, 1'b0, 9, 1'b0);
    tick();
    set1(1'b1, 1'b1, 9, 1'b0);
    tick();
    req1_vld = 1'b0;
    set0(1'b1, 1'b0, 9, 1'b0);
    tick();
    idle();
    tick();
    check_seq("t6_req", rsp_req_log, '{1, 0});
    check_seq("t6_rd", rsp_dat_log, '{1, 0});

    // Random traffic against the model.
    repeat (4000) begin
      set0(1'($urandom_range(0, 2) != 0), 1'($urandom),
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15)),
           1'($urandom));
      set1(1'($urandom_range(0, 2) != 0), 1'($urandom),
           ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15)),
           1'($urandom));
      clr_start = ($urandom_range(0, 599) == 0);
      rst_n     = ($urandom_range(0, 1499) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 1024x1-bit RAM between two requesters (req0, req1) using round-robin arbitration and valid/ready handshakes.
- Returns read data with a one-cycle response strobe, matching the RAM's registered read address.
- Contains a clear sequencer that sweeps the whole RAM with a fixed value on command.
- Sits directly in front of the RAM and drives its data, addr and we inputs.

Parameters:
- ADDR_W, 10, RAM address width.
- DEPTH, 2**ADDR_W, number of RAM entries; the clear sweep covers 0..DEPTH-1.
- CLR_VAL, 1'b0, bit written to every entry during a clear.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_vld  in  1  requester 0 has a valid access.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  access address.
- req0_wdata  in  1  write data.
- req0_rdy  out  1  access accepted this cycle (handshake = vld & rdy).
- req0_rsp_vld  out  1  read data valid on req0_rsp_data.
- req0_rsp_data  out  1  read data.
- req1_vld, req1_we, req1_addr, req1_wdata, req1_rdy, req1_rsp_vld, req1_rsp_data: same as req0_*, for requester 1.
- clr_start  in  1  single-cycle request to start a clear sweep.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse when a sweep completes.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_data  out  1  to RAM data.
- ram_we  out  1  to RAM we.
- ram_q  in  1  from RAM q (combinational read of the registered address).

Behaviour:
- Reset values: state = SERVE, clr_cnt = 0, last_grant = 1 (so req0 wins the first tie), rsp_vld regs = 0, clr_busy = 0, clr_done = 0.
- While rst_n is low: ram_we = 0, req*_rdy = 0.
- FSM has two states:
  - SERVE: arbitration active; clr_start moves to CLEAR on the next edge. Handshakes in the clr_start cycle still complete.
  - CLEAR: both rdy = 0. Each cycle drives ram_addr = clr_cnt, ram_data = CLR_VAL, ram_we = 1. When clr_cnt == DEPTH-1, the FSM returns to SERVE and clr_cnt resets to 0.
- clr_busy is high exactly while state == CLEAR (DEPTH cycles).
- clr_done is registered: it pulses in the first SERVE cycle after the sweep.
- clr_start while in CLEAR is ignored.
- Arbitration in SERVE (combinational grant):
  - Only one valid requester: it is granted.
  - Both valid: grant the one not equal to last_grant.
  - None valid: no grant and ram_we = 0. ram_addr holds the last driven value; it is don't-care, but must not toggle we.
  - last_grant updates only on a granted cycle.
- The granted requester's rdy = 1 and the other's rdy = 0. rdy never depends on the loser's vld.
- The granted requester's addr, wdata and we drive ram_addr, ram_data and ram_we in the same cycle.
- Write: completes at the handshake edge; no response strobe.
- Read:
  - At the handshake edge the RAM captures the address and the controller sets reqN_rsp_vld for one cycle.
  - reqN_rsp_data = ram_q during that cycle, so latency = 1 cycle.
  - Back-to-back reads give back-to-back rsp_vld.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Both rsp_data outputs may be wired to ram_q; only rsp_vld qualifies them.
- Reset mid-clear: sweep aborts, no clr_done, state = SERVE. Partially cleared contents are not restored.
- Reset during a pending read response: rsp_vld is forced to 0.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - ADDR_W default constant.
  - State enum: SERVE, CLEAR.
  - Requester-index constants.
- One natural sub-module: rr_arb2 (2-way round-robin with last_grant register, inputs vld[1:0], output one-hot gnt[1:0]).

Test Plan:
- Reset, then req0 writes 1 to addr 5, then req0 reads addr 5 -> req0_rdy high both cycles; req0_rsp_vld pulses 1 cycle after the read handshake with data 1.
- req0 and req1 both hold vld high for 4 cycles (reads of addrs 3 and 7) -> grants alternate 0,1,0,1; each rsp_vld pulses one cycle after its grant.
- req1 alone requests for 3 cycles, then both request -> req1 granted 3 times, then req0 wins the tie (last_grant = 1).
- Write 1 to addrs 0, 512 and 1023, pulse clr_start -> clr_busy high for 1024 cycles with both rdy = 0; clr_done pulses once; reads of 0, 512 and 1023 return 0.
- Assert rst_n low at clr_cnt = 300 -> clr_busy = 0 and clr_done never pulses; addr 299 reads 0 and addr 301 keeps its prior value.
- Write then read addr 9 in consecutive cycles from different requesters -> the read returns the new value.
